// File: rtl/fifo_reader_if.sv
// Handshake bundle between fifo_reader, the FIFO it drains and the downstream sink.
// The master side drives requests and FIFO status; slave is the reader itself.
interface fifo_reader_if #(
  parameter int W  = 4,
  parameter int LW = 5
);
  logic          start;
  logic [LW-1:0] burst_len;
  logic          abort;
  logic [W-1:0]  fifo_d_out;
  logic          fifo_empty;
  logic          fifo_pop;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          done;
  logic          timeout;
  logic [LW-1:0] words_left;

  modport master (
    output start, burst_len, abort, fifo_d_out, fifo_empty, out_ready,
    input  fifo_pop, out_data, out_valid, busy, done, timeout, words_left
  );

  modport slave (
    input  start, burst_len, abort, fifo_d_out, fifo_empty, out_ready,
    output fifo_pop, out_data, out_valid, busy, done, timeout, words_left
  );
endinterface

// File: rtl/fifo_reader.sv
// Burst reader: pops up to burst_len words from a fall-through FIFO into a
// one-word registered output stage, with abort and empty-FIFO timeout.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | popping words while FIFO and sink allow
// DRAIN | all words popped (or timed out); waiting for the last word to leave
// DONE  | one-cycle done pulse, then back to IDLE
module fifo_reader #(
  parameter int W   = 4,
  parameter int LW  = 5,
  parameter int TMO = 16
) (
  input  logic        clk,
  input  logic        reset,
  fifo_reader_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [W-1:0]  out_data_q;
  logic          out_valid_q;
  logic [LW-1:0] words_left_q;
  logic          timeout_q;
  logic [7:0]    empty_cnt;

  logic pop;
  logic handshake;
  logic abort_act;
  logic tmo_hit;

  assign handshake = out_valid_q & bus.out_ready;
  assign pop       = (state == RUN) & ~bus.fifo_empty & ~bus.abort
                     & (~out_valid_q | bus.out_ready);
  assign abort_act = bus.abort & ((state == RUN) | (state == DRAIN));
  // Counter holds TMO-1 on the empty cycle that completes the timeout window.
  assign tmo_hit   = (state == RUN) & bus.fifo_empty & ~bus.abort
                     & (empty_cnt == 8'(TMO - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.start) state_nxt = (bus.burst_len != '0) ? RUN : DONE;
      end
      RUN: begin
        if (bus.abort)                              state_nxt = DONE;
        else if (pop && words_left_q == LW'(1))     state_nxt = DRAIN;
        else if (tmo_hit)                           state_nxt = DRAIN;
      end
      DRAIN: begin
        if (bus.abort || !out_valid_q || handshake) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      words_left_q <= '0;
      timeout_q    <= 1'b0;
      empty_cnt    <= '0;
    end else begin
      if (state == IDLE && bus.start) begin
        words_left_q <= bus.burst_len;
        timeout_q    <= 1'b0;
        empty_cnt    <= '0;
      end

      // Pops only happen in RUN, where words_left is at least 1, so no wrap.
      if (abort_act) begin
        out_valid_q <= 1'b0;
      end else if (pop) begin
        out_data_q   <= bus.fifo_d_out;
        out_valid_q  <= 1'b1;
        words_left_q <= words_left_q - LW'(1);
      end else if (handshake) begin
        out_valid_q <= 1'b0;
      end

      if (state == RUN) begin
        if (pop)
          empty_cnt <= '0;
        else if (bus.fifo_empty && empty_cnt != 8'hFF)
          empty_cnt <= empty_cnt + 8'd1;
      end

      if (tmo_hit) timeout_q <= 1'b1;
    end
  end

  assign bus.fifo_pop   = pop;
  assign bus.out_data   = out_data_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.busy       = (state != IDLE);
  assign bus.done       = (state == DONE);
  assign bus.timeout    = timeout_q;
  assign bus.words_left = words_left_q;

endmodule

// File: doc/fifo_reader.md
FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001 Parameter W, default 4, data word width; SHALL match the attached FIFO width.
REQ-002 Parameter LW, default 5, burst-length and words_left width.
REQ-003 Parameter TMO, default 16, consecutive empty cycles in RUN before timeout; legal range 1..255.
REQ-004 clk  input  1  single clock; all state SHALL update on posedge clk.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  one-cycle burst request, sampled only in IDLE.
REQ-007 burst_len  input  LW  number of words to read, sampled with start.
REQ-008 abort  input  1  terminates the active burst.
REQ-009 fifo_d_out  input  W  FIFO head word, fall-through, valid whenever fifo_empty=0.
REQ-010 fifo_empty  input  1  FIFO empty flag.
REQ-011 fifo_pop  output  1  removes the FIFO head at the next posedge clk.
REQ-012 out_data  output  W  registered word presented to the sink.
REQ-013 out_valid  output  1  out_data holds an undelivered word.
REQ-014 out_ready  input  1  sink accepts out_data when out_valid=1 and out_ready=1.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle pulse at burst end.
REQ-017 timeout  output  1  sticky flag; set on timeout, cleared on the next accepted start.
REQ-018 words_left  output  LW  words still to pop in the current burst.

Function
REQ-019 The FSM SHALL have states IDLE, RUN, DRAIN and DONE, with binary encoding.
REQ-020 IDLE: a start with burst_len!=0 SHALL go to RUN, load words_left<=burst_len, clear timeout and clear the empty counter.
REQ-021 IDLE: a start with burst_len=0 SHALL go directly to DONE and pop nothing.
REQ-022 start in any state other than IDLE SHALL be ignored.
REQ-023 fifo_pop SHALL be combinational and equal (state==RUN) & !fifo_empty & !abort & (!out_valid | out_ready).
REQ-024 On a pop edge: out_data<=fifo_d_out, out_valid<=1 and words_left<=words_left-1; at words_left==1 the FSM SHALL go to DRAIN.
REQ-025 A handshake (out_valid & out_ready) with no pop in the same cycle SHALL clear out_valid; a handshake with a pop in the same cycle SHALL reload out_data and keep out_valid=1.
REQ-026 While out_valid=1 and out_ready=0, out_data and out_valid SHALL remain stable.
REQ-027 Sustained throughput SHALL be 1 word/clk when fifo_empty=0 and out_ready=1.
REQ-028 Pop-to-out_valid latency SHALL be one clock.
REQ-029 Empty counter: in RUN it SHALL increment on each cycle with fifo_empty=1 and SHALL reset on each pop; on reaching TMO the block SHALL set timeout=1 and go to DRAIN.
REQ-030 DRAIN SHALL go to DONE on the first edge where out_valid=0 or a handshake occurs.
REQ-031 abort in RUN or DRAIN SHALL go to DONE, clear out_valid (discarding the held word) and force fifo_pop=0 in that cycle.
REQ-032 DONE SHALL assert done for exactly one cycle and then go to IDLE.
REQ-033 words_left SHALL never wrap below 0, and timeout SHALL NOT affect words_left.

Reset
REQ-034 Reset assertion SHALL immediately force state=IDLE, out_data=0, out_valid=0, done=0, timeout=0, words_left=0, busy=0, empty counter=0 and fifo_pop=0, independent of clk.
REQ-035 Reset mid-burst SHALL abandon the burst without a done pulse; after reset is released, the first start SHALL behave as in REQ-020.

Verification
REQ-036 The bench SHALL cover the following scenarios:
- FIFO preloaded with 1..8, burst_len=8, out_ready=1 -> 8 consecutive pops, out_data 1..8 on consecutive cycles, done pulses 1 clk after the last handshake, words_left=0.
- Same setup with out_ready toggled 1010... -> data order 1..8 preserved, no word lost or duplicated, out_data stable while stalled.
- FIFO holds 3 words, burst_len=5, TMO=16 -> 3 words delivered, timeout=1 after 16 empty cycles, done pulses, words_left=2.
- Burst of 10, abort asserted after the 4th pop -> no pop in the abort cycle, out_valid=0 next clk, done pulses, 6 words remain in the FIFO.
- Async reset asserted mid-burst between clk edges -> outputs go to 0 immediately, no done pulse; a new start with burst_len=2 completes normally.
- start with burst_len=0 -> no pop, busy high for 1 clk, done pulses; a start pulsed during RUN is ignored.
